// File: rtl/fifo_reorder_pkg.sv
// fifo_reorder_pkg
//   Shared definitions for the reorder FIFO slice.
//   - MIN_ELS : smallest legal entry count
//   - is_pow2 : elaboration-time helper used to validate els_p
package fifo_reorder_pkg;

    localparam int unsigned MIN_ELS = 2;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_reorder_if.sv
// fifo_reorder_if
//   Bundles the allocate, write-back and dequeue handshakes of fifo_reorder.
//   slave  : the FIFO side (drives alloc id/valid, deq data/valid, empty)
//   master : the consumer / network side (drives the yumis and the write port)
interface fifo_reorder_if #(
    parameter int width_p = 32,
    parameter int els_p   = 4
);
    localparam int lg_els_lp = $clog2(els_p);

    logic [lg_els_lp-1:0] fifo_alloc_id_o;
    logic                 fifo_alloc_v_o;
    logic                 fifo_alloc_yumi_i;
    logic [lg_els_lp-1:0] write_id_i;
    logic [width_p-1:0]   write_data_i;
    logic                 write_v_i;
    logic [width_p-1:0]   fifo_deq_data_o;
    logic                 fifo_deq_v_o;
    logic                 fifo_deq_yumi_i;
    logic                 empty_o;

    modport slave (
        output fifo_alloc_id_o, fifo_alloc_v_o, fifo_deq_data_o, fifo_deq_v_o, empty_o,
        input  fifo_alloc_yumi_i, write_id_i, write_data_i, write_v_i, fifo_deq_yumi_i
    );

    modport master (
        input  fifo_alloc_id_o, fifo_alloc_v_o, fifo_deq_data_o, fifo_deq_v_o, empty_o,
        output fifo_alloc_yumi_i, write_id_i, write_data_i, write_v_i, fifo_deq_yumi_i
    );
endinterface

// File: rtl/fifo_reorder_mem.sv
// mem_1r1w_async
//   Register-file storage: one synchronous write port, one asynchronous read port.
//   Contents are not reset.
//   clk_i              : write clock
//   w_v_i/w_addr_i/w_data_i : write strobe, address, data
//   r_addr_i/r_data_o  : combinational read
module mem_1r1w_async
    import fifo_reorder_pkg::*;
#(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       w_v_i,
    input  logic [$clog2(els_p)-1:0]   w_addr_i,
    input  logic [width_p-1:0]         w_data_i,
    input  logic [$clog2(els_p)-1:0]   r_addr_i,
    output logic [width_p-1:0]         r_data_o
);
    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/fifo_reorder.sv
// fifo_reorder
//   Hands out sequential transaction IDs, accepts completions by ID in any
//   order, and returns completion data strictly in allocation order.
//   clk_i     : rising-edge clock
//   reset_n_i : asynchronous active-low reset (pointers and written flags)
//   bus       : fifo_reorder_if.slave (alloc / write / dequeue handshakes)
//   All outputs come from registered state; there is no input-to-output path.
module fifo_reorder
    import fifo_reorder_pkg::*;
#(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    fifo_reorder_if.slave  bus
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam int ptr_w_lp  = lg_els_lp + 1;

    if (els_p < int'(MIN_ELS) || !is_pow2(els_p)) begin : g_bad_els
        $error("fifo_reorder: els_p must be a power of two >= 2");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ptr_w_lp-1:0]  wptr_q, wptr_d;
    logic [ptr_w_lp-1:0]  rptr_q, rptr_d;
    logic [els_p-1:0]     valid_q, valid_d;

    logic [lg_els_lp-1:0] rd_idx;
    logic                 full;
    logic                 alloc_fire;
    logic                 deq_fire;

    assign rd_idx = rptr_q[lg_els_lp-1:0];
    assign full   = (wptr_q[lg_els_lp-1:0] == rptr_q[lg_els_lp-1:0])
                 && (wptr_q[lg_els_lp] != rptr_q[lg_els_lp]);

    // Each yumi is gated by its own valid so an illegal strobe cannot
    // advance a pointer past the live window.
    assign alloc_fire = bus.fifo_alloc_yumi_i & ~full;
    assign deq_fire   = bus.fifo_deq_yumi_i & valid_q[rd_idx];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        if (alloc_fire) begin
            wptr_d = wptr_q + ptr_w_lp'(1);
        end
        if (deq_fire) begin
            rptr_d          = rptr_q + ptr_w_lp'(1);
            valid_d[rd_idx] = 1'b0;
        end
        // A legal write never targets the head being popped, so set and
        // clear always land on different bits.
        if (bus.write_v_i) begin
            valid_d[bus.write_id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
        end
    end

    mem_1r1w_async #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (bus.write_v_i),
        .w_addr_i (bus.write_id_i),
        .w_data_i (bus.write_data_i),
        .r_addr_i (rd_idx),
        .r_data_o (bus.fifo_deq_data_o)
    );

    assign bus.fifo_alloc_id_o = wptr_q[lg_els_lp-1:0];
    assign bus.fifo_alloc_v_o  = ~full;
    assign bus.fifo_deq_v_o    = valid_q[rd_idx];
    assign bus.empty_o         = (wptr_q == rptr_q);

endmodule

// File: tb/tb_fifo_reorder.sv
// tb_fifo_reorder
//   Directed, table-driven bench for fifo_reorder with els_p=4, width_p=32.
//   Each vector drives one cycle of inputs and lists the outputs expected
//   just after that rising edge.
module tb_fifo_reorder;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_reorder_if #(.width_p(W), .els_p(N)) bus ();

    fifo_reorder #(.width_p(W), .els_p(N)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic        alloc;
        logic        wv;
        logic [1:0]  wid;
        logic [31:0] wd;
        logic        deq;
        logic        av;
        logic [1:0]  aid;
        logic        dv;
        logic [31:0] dd;
        logic        emp;
    } vec_t;

    vec_t vq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Bench-side bookkeeping used only to flag illegal write stimulus.
    logic [2:0] m_wp = '0;
    logic [2:0] m_rp = '0;
    logic [3:0] m_wr = '0;

    function automatic vec_t mk(input int a, input int wv, input int wid, input logic [31:0] wd,
                                input int dq, input int av, input int aid, input int dv,
                                input logic [31:0] dd, input int e);
        vec_t v;
        v.alloc = a[0];
        v.wv    = wv[0];
        v.wid   = wid[1:0];
        v.wd    = wd;
        v.deq   = dq[0];
        v.av    = av[0];
        v.aid   = aid[1:0];
        v.dv    = dv[0];
        v.dd    = dd;
        v.emp   = e[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        bus.fifo_alloc_yumi_i = 1'b0;
        bus.write_v_i         = 1'b0;
        bus.write_id_i        = '0;
        bus.write_data_i      = '0;
        bus.fifo_deq_yumi_i   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " alloc_v"}, 32'(bus.fifo_alloc_v_o), 32'd1);
        chk({tag, " alloc_id"}, 32'(bus.fifo_alloc_id_o), 32'd0);
        chk({tag, " deq_v"}, 32'(bus.fifo_deq_v_o), 32'd0);
        chk({tag, " empty"}, 32'(bus.empty_o), 32'd1);
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [1:0] off;
        logic       m_full;
        off    = v.wid - m_rp[1:0];
        m_full = (m_wp[1:0] == m_rp[1:0]) && (m_wp[2] != m_rp[2]);
        if (v.wv && (({1'b0, off} >= (m_wp - m_rp)) || m_wr[v.wid])) begin
            n_total++;
            $display("FAIL %s illegal_write: id %0d not outstanding or already written", tag, v.wid);
        end
        bus.fifo_alloc_yumi_i = v.alloc;
        bus.write_v_i         = v.wv;
        bus.write_id_i        = v.wid;
        bus.write_data_i      = v.wd;
        bus.fifo_deq_yumi_i   = v.deq;
        @(posedge clk);
        #1;
        if (v.deq && m_wr[m_rp[1:0]]) begin
            m_wr[m_rp[1:0]] = 1'b0;
            m_rp            = m_rp + 3'd1;
        end
        if (v.wv) m_wr[v.wid] = 1'b1;
        if (v.alloc && !m_full) m_wp = m_wp + 3'd1;
        idle_inputs();
        chk({tag, " alloc_v"}, 32'(bus.fifo_alloc_v_o), 32'(v.av));
        chk({tag, " alloc_id"}, 32'(bus.fifo_alloc_id_o), 32'(v.aid));
        chk({tag, " deq_v"}, 32'(bus.fifo_deq_v_o), 32'(v.dv));
        if (v.dv) chk({tag, " deq_data"}, bus.fifo_deq_data_o, v.dd);
        chk({tag, " empty"}, 32'(bus.empty_o), 32'(v.emp));
    endtask

    initial begin
        int nb;
        idle_inputs();

        //        alloc wv wid wdata    deq | av aid dv deq_data  empty
        // In-order fill to full, illegal alloc while full, then drain.
        vq.push_back(mk(1, 0, 0, 32'h0,  0,   1, 1, 0, 32'h0,  0));
        vq.push_back(mk(1, 1, 0, 32'hA0, 0,   1, 2, 1, 32'hA0, 0));
        vq.push_back(mk(1, 1, 1, 32'hA1, 0,   1, 3, 1, 32'hA0, 0));
        vq.push_back(mk(1, 1, 2, 32'hA2, 0,   0, 0, 1, 32'hA0, 0));
        vq.push_back(mk(1, 1, 3, 32'hA3, 0,   0, 0, 1, 32'hA0, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 0, 1, 32'hA1, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 0, 1, 32'hA2, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 0, 1, 32'hA3, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 0, 0, 32'h0,  1));
        // Out-of-order completions: 2, 0, 3, 1; illegal deq while head unwritten.
        vq.push_back(mk(1, 0, 0, 32'h0,  0,   1, 1, 0, 32'h0,  0));
        vq.push_back(mk(1, 0, 0, 32'h0,  0,   1, 2, 0, 32'h0,  0));
        vq.push_back(mk(1, 0, 0, 32'h0,  0,   1, 3, 0, 32'h0,  0));
        vq.push_back(mk(1, 0, 0, 32'h0,  0,   0, 0, 0, 32'h0,  0));
        vq.push_back(mk(0, 1, 2, 32'hC2, 0,   0, 0, 0, 32'h0,  0));
        vq.push_back(mk(0, 1, 0, 32'hC0, 0,   0, 0, 1, 32'hC0, 0));
        vq.push_back(mk(0, 1, 3, 32'hC3, 1,   1, 0, 0, 32'h0,  0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 0, 0, 32'h0,  0));
        vq.push_back(mk(0, 1, 1, 32'hC1, 0,   1, 0, 1, 32'hC1, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 0, 1, 32'hC2, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 0, 1, 32'hC3, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 0, 0, 32'h0,  1));
        nb = vq.size();
        // Concurrent full boundary (from reset): fill, then pop + write 3 + blocked alloc.
        vq.push_back(mk(1, 0, 0, 32'h0,  0,   1, 1, 0, 32'h0,  0));
        vq.push_back(mk(1, 1, 0, 32'hD0, 0,   1, 2, 1, 32'hD0, 0));
        vq.push_back(mk(1, 1, 1, 32'hD1, 0,   1, 3, 1, 32'hD0, 0));
        vq.push_back(mk(1, 1, 2, 32'hD2, 0,   0, 0, 1, 32'hD0, 0));
        vq.push_back(mk(1, 1, 3, 32'hD3, 1,   1, 0, 1, 32'hD1, 0));
        vq.push_back(mk(1, 0, 0, 32'h0,  0,   0, 1, 1, 32'hD1, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 1, 1, 32'hD2, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 1, 1, 32'hD3, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 1, 0, 32'h0,  0));
        vq.push_back(mk(0, 1, 0, 32'hD4, 0,   1, 1, 1, 32'hD4, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,  1,   1, 1, 0, 32'h0,  1));

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("post_reset");

        for (int i = 0; i < nb; i++) begin
            apply(vq[i], $sformatf("v%0d", i));
        end

        // Ten allocate/write/dequeue rounds; IDs wrap 0..3.
        for (int r = 0; r < 10; r++) begin
            logic [1:0]  id;
            logic [1:0]  nid;
            logic [31:0] d;
            id  = 2'(r);
            nid = 2'(r + 1);
            d   = 32'hB0 + 32'(r);
            apply(mk(1, 0, 0, 32'h0, 0, 1, int'(nid), 0, 32'h0, 0), $sformatf("wrap%0d_alloc", r));
            apply(mk(0, 1, int'(id), d, 0, 1, int'(nid), 1, d, 0), $sformatf("wrap%0d_write", r));
            apply(mk(0, 0, 0, 32'h0, 1, 1, int'(nid), 0, 32'h0, 1), $sformatf("wrap%0d_deq", r));
        end

        // Three outstanding (IDs 2,3,0 with 2 written), then reset between edges.
        apply(mk(1, 0, 0, 32'h0,  0, 1, 3, 0, 32'h0,  0), "pre_rst0");
        apply(mk(1, 0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  0), "pre_rst1");
        apply(mk(1, 1, 2, 32'hE2, 0, 1, 1, 1, 32'hE2, 0), "pre_rst2");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        #3;
        rst_n = 1'b1;
        m_wp = '0;
        m_rp = '0;
        m_wr = '0;
        apply(mk(0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1), "after_rst");

        for (int i = nb; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("bnd%0d", i - nb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time exceeded, %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_reorder.md
# fifo_reorder

Reorder FIFO for tagging out-of-order completions and returning them in request order. A consumer allocates sequential transaction IDs before issuing requests. Completions are written back by ID in any order. Data is dequeued strictly in allocation order, and only once the oldest entry has been written. It sits between a request issuer and an out-of-order network response path, for example to match manycore load/credit returns to in-order bridge responses.

## Interface
- `width_p`, no default (must be set), width of the data payload in bits.
- `els_p`, no default (must be set, power of two ≥ 2), number of entries and of outstanding IDs; `lg_els_lp = clog2(els_p)`.

Ports:
- `clk_i` input 1: the single clock, rising edge.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `fifo_alloc_id_o` output `lg_els_lp`: next ID to allocate.
- `fifo_alloc_v_o` output 1: an ID is available (FIFO not full).
- `fifo_alloc_yumi_i` input 1: consume the presented ID. Legal only when `fifo_alloc_v_o`=1.
- `write_id_i` input `lg_els_lp`: ID of the completing entry.
- `write_data_i` input `width_p`: completion data.
- `write_v_i` input 1: write strobe.
- `fifo_deq_data_o` output `width_p`: data of the oldest entry.
- `fifo_deq_v_o` output 1: the oldest entry is allocated and written.
- `fifo_deq_yumi_i` input 1: pop the oldest entry. Legal only when `fifo_deq_v_o`=1.
- `empty_o` output 1: no entries are allocated.

## Operation
- **State:**
  - `wptr_r` and `rptr_r`, each `lg_els_lp+1` bits; the MSB is the wrap bit.
  - `valid_r[els_p]`: written flags.
  - Data storage, `els_p` × `width_p`.
- **Allocation:**
  - `fifo_alloc_id_o` is the low `lg_els_lp` bits of `wptr_r`.
  - `fifo_alloc_v_o = !full`.
  - `full` means the low bits of the two pointers are equal and the wrap bits differ.
  - On `fifo_alloc_yumi_i`, `wptr_r` increments (modulo `2·els_p`).
- **Write:**
  - On `write_v_i`, `mem[write_id_i] <= write_data_i` and `valid_r[write_id_i] <= 1`.
  - `write_id_i` must reference an ID allocated in an earlier cycle and not yet dequeued. The block does not check this; the bench flags violations.
  - Rewriting an entry that is already valid is illegal.
- **Dequeue:**
  - `fifo_deq_v_o = valid_r[rptr_r low bits]`.
  - `fifo_deq_data_o = mem[rptr_r low bits]`, read asynchronously.
  - On `fifo_deq_yumi_i`, that entry's valid flag clears and `rptr_r` increments.
- **Empty:** `empty_o = (wptr_r == rptr_r)`, full width including the wrap bit.
- **Simultaneous events:**
  - Allocate, write and dequeue may all occur in the same cycle on distinct entries.
  - A write and a valid-clear to different indices both take effect.
  - A write to the entry being dequeued cannot occur, because dequeue requires the entry to be valid already.
- **Illegal strobes:** a yumi without the matching valid is illegal. The pointers must still not corrupt; the design gates each increment with its own valid.

## Timing
- **Reset (asynchronous assert, synchronous-safe deassert):**
  - `wptr_r=0`, `rptr_r=0`, all `valid_r=0`.
  - Resulting outputs: `fifo_alloc_v_o=1`, `fifo_alloc_id_o=0`, `fifo_deq_v_o=0`, `empty_o=1`.
  - Data storage is not reset, so `fifo_deq_data_o` is don't-care while `fifo_deq_v_o=0`.
- **Reset mid-operation:** all outstanding IDs and data are discarded.
- **No combinational paths:** every output depends only on registered state. There is no input-to-output path, so a write does not bypass to the dequeue outputs.
- **Latencies:**
  - Write to dequeue-visible: 1 cycle. A write at edge N makes `fifo_deq_v_o`=1 after edge N if that entry is the head.
  - Dequeue to the slot reappearing for allocation: 1 cycle. When full, a pop at edge N raises `fifo_alloc_v_o` after edge N.
- **Wrap-around:** IDs cycle 0…`els_p`-1, 0, …; the wrap bit disambiguates full from empty.

## Structure
- No shared package is required; `lg_els_lp` is a local parameter.
- One natural sub-module: `mem_1r1w_async`, a register-file storage array with a synchronous write port and an asynchronous read port.
- Pointers, valid flags and the full/empty logic live in the top module.

## Test plan
- **Reset:** after reset, `fifo_alloc_v_o=1`, `fifo_alloc_id_o=0`, `empty_o=1`, `fifo_deq_v_o=0`.
- **In-order:** `els_p=4`, `width_p=32`. Allocate IDs 0–3 and write 0xA0–0xA3 in order.
  - `fifo_alloc_v_o=0` after the 4th allocation.
  - Dequeue returns 0xA0, 0xA1, 0xA2, 0xA3, then `empty_o=1`.
- **Out-of-order:** allocate 0–3, then write ID 2 (0xC2), ID 0 (0xC0), ID 3 (0xC3), ID 1 (0xC1).
  - `fifo_deq_v_o` rises 1 cycle after the ID 0 write; 0xC0 pops.
  - The head then stalls until ID 1 is written, after which 0xC1, 0xC2, 0xC3 pop.
- **Wrap-around:** with `els_p=4`, run 10 allocate/write/dequeue rounds.
  - IDs wrap 0,1,2,3,0,…; data returns in order.
  - `empty_o=1` at the end.
- **Concurrent full boundary:** start full with the head valid. In one cycle, pop while writing ID 3 and attempting allocation.
  - Allocation stays blocked that cycle.
  - The next cycle shows `fifo_alloc_v_o=1` with `fifo_alloc_id_o=0`.
- **Async reset mid-run:** assert `reset_n_i` between clock edges with 3 entries outstanding.
  - Outputs return to their reset values immediately, without waiting for a clock edge.
